// File: rtl/err_rcvr.sv
`default_nettype none
// ============================================================================
//  Module   : err_rcvr
//  Purpose  : Consumer end of the four-phase error-reporting req/ack
//             handshake. Each transfer stores one error word in a small
//             show-ahead FIFO; ack is withheld while the FIFO is full.
//  Revision : 1.0 - initial release
// ============================================================================
module err_rcvr #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    // upstream handshake
    input  logic              err_req,
    input  logic [DATA_W-1:0] err_data,
    output logic              err_ack,
    // readout port
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   level,
    output logic              stall,
    output logic [CNT_W-1:0]  rx_cnt
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int              c_DEPTH_INT = 1 << ADDR_W;
    localparam logic [ADDR_W:0] c_DEPTH     = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] c_LVL_ZERO  = '0;
    localparam logic [CNT_W-1:0] c_CNT_MAX  = {CNT_W{1'b1}};

    // Handshake FSM encoding; the 2-bit width leaves spare codes that are
    // steered back to idle.
    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_ACK  = 2'd1;

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;

    logic              r_ack;
    logic              w_ack_nxt;
    logic              r_stall;
    logic              w_stall_nxt;
    logic              w_accept;
    logic              w_pop;

    logic [DATA_W-1:0] r_mem [c_DEPTH_INT];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_level;
    logic [CNT_W-1:0]  r_rx_cnt;

    logic              w_full;
    logic              w_empty;

    // Full/empty come from the stored level (pre-pop), never from pointers.
    assign w_full  = (r_level == c_DEPTH);
    assign w_empty = (r_level == c_LVL_ZERO);

    // A pop is only honoured when there is something to pop.
    assign w_pop   = rd_en && !w_empty;

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next-state logic: one accept per request, then wait for req to drop
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = c_S_IDLE;
        case (r_state)
            c_S_IDLE: begin
                if (err_req && !w_full) begin
                    w_state_nxt = c_S_ACK;
                end else begin
                    w_state_nxt = c_S_IDLE;
                end
            end
            c_S_ACK: begin
                if (err_req) begin
                    w_state_nxt = c_S_ACK;
                end else begin
                    w_state_nxt = c_S_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM output logic: write strobe plus next values of ack and stall
    // ------------------------------------------------------------------------
    always_comb begin
        w_accept    = 1'b0;
        w_ack_nxt   = 1'b0;
        w_stall_nxt = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                w_accept    = err_req && !w_full;
                w_ack_nxt   = err_req && !w_full;
                w_stall_nxt = err_req &&  w_full;
            end
            c_S_ACK: begin
                // Ack stays up until req is seen low; no further writes here.
                w_ack_nxt   = err_req;
            end
            default: begin
                w_accept    = 1'b0;
                w_ack_nxt   = 1'b0;
                w_stall_nxt = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Registered handshake outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ack   <= 1'b0;
            r_stall <= 1'b0;
        end else begin
            r_ack   <= w_ack_nxt;
            r_stall <= w_stall_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FIFO storage; contents need no reset since level gates visibility
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_wr_ptr] <= err_data;
        end
    end

    // ------------------------------------------------------------------------
    // FIFO pointers and fill level
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            end
            // Simultaneous accept and pop cancel out in the level.
            case ({w_accept, w_pop})
                2'b10:   r_level <= r_level + (ADDR_W+1)'(1);
                2'b01:   r_level <= r_level - (ADDR_W+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Saturating count of accepted words
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_cnt <= '0;
        end else if (w_accept && (r_rx_cnt != c_CNT_MAX)) begin
            r_rx_cnt <= r_rx_cnt + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Output mapping; the read port is show-ahead and reads as zero when empty
    // ------------------------------------------------------------------------
    assign err_ack = r_ack;
    assign stall   = r_stall;
    assign empty   = w_empty;
    assign full    = w_full;
    assign level   = r_level;
    assign rx_cnt  = r_rx_cnt;
    assign rd_data = w_empty ? '0 : r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: tb/tb_err_rcvr.sv
`default_nettype none
// ============================================================================
//  Module   : tb_err_rcvr
//  Purpose  : Self-checking bench for err_rcvr. Words issued upstream are
//             queued as expected read data; a monitor pops and compares on
//             every honoured read.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_err_rcvr;

    logic        clk = 1'b0;
    logic        rst;
    logic        err_req;
    logic [31:0] err_data;
    logic        err_ack;
    logic        rd_en;
    logic [31:0] rd_data;
    logic        empty;
    logic        full;
    logic [4:0]  level;
    logic        stall;
    logic [15:0] rx_cnt;

    // small-counter instance for the saturation check
    logic        s_req;
    logic [31:0] s_data;
    logic        s_ack;
    logic        s_rd_en;
    logic [31:0] s_rd_data;
    logic        s_empty;
    logic        s_full;
    logic [4:0]  s_level;
    logic        s_stall;
    logic [1:0]  s_cnt;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    err_rcvr #(.DATA_W(32), .ADDR_W(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .err_req(err_req), .err_data(err_data),
        .err_ack(err_ack), .rd_en(rd_en), .rd_data(rd_data), .empty(empty),
        .full(full), .level(level), .stall(stall), .rx_cnt(rx_cnt)
    );

    err_rcvr #(.DATA_W(32), .ADDR_W(4), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .err_req(s_req), .err_data(s_data),
        .err_ack(s_ack), .rd_en(s_rd_en), .rd_data(s_rd_data), .empty(s_empty),
        .full(s_full), .level(s_level), .stall(s_stall), .rx_cnt(s_cnt)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every honoured pop must present the oldest issued word.
    always @(negedge clk) begin
        logic [31:0] e;
        if (!rst && rd_en && !empty) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL pop_unexpected: got %0h expected none", rd_data);
            end else begin
                e = exp_q.pop_front();
                if (rd_data !== e) begin
                    bad++;
                    $display("FAIL pop_data: got %0h expected %0h", rd_data, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input logic val, input string nm);
        int n = 0;
        while (err_ack !== val && n < 50) begin
            tick();
            n++;
        end
        chk(nm, {63'd0, err_ack}, {63'd0, val});
    endtask

    task automatic send(input logic [31:0] d);
        err_data = d;
        err_req  = 1'b1;
        exp_q.push_back(d);
        wait_ack(1'b1, "send_ack_rise");
        err_req = 1'b0;
        wait_ack(1'b0, "send_ack_fall");
    endtask

    task automatic pop1();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (!empty && n < 64) begin
            rd_en = 1'b1;
            tick();
            n++;
        end
        rd_en = 1'b0;
        chk("drain_empty", {63'd0, empty}, 64'd1);
        chk("drain_queue", exp_q.size(), 64'd0);
    endtask

    initial begin
        logic [15:0] cnt0;
        rst = 1'b1; err_req = 1'b0; err_data = '0; rd_en = 1'b0;
        s_req = 1'b0; s_data = '0; s_rd_en = 1'b0;
        repeat (3) tick();
        chk("rst_ack",   {63'd0, err_ack}, 64'd0);
        chk("rst_empty", {63'd0, empty},   64'd1);
        chk("rst_full",  {63'd0, full},    64'd0);
        chk("rst_level", level,            64'd0);
        chk("rst_stall", {63'd0, stall},   64'd0);
        chk("rst_rxcnt", rx_cnt,           64'd0);
        chk("rst_rdata", rd_data,          64'd0);
        rst = 1'b0;
        tick();

        // read on empty is a no-op
        pop1();
        chk("emptyrd_level", level, 64'd0);
        chk("emptyrd_rdata", rd_data, 64'd0);

        // single transfer
        err_data = 32'hDEADBEEF;
        err_req  = 1'b1;
        exp_q.push_back(32'hDEADBEEF);
        tick();
        chk("single_ack",   {63'd0, err_ack}, 64'd1);
        chk("single_rdata", rd_data, 64'hDEADBEEF);
        chk("single_level", level, 64'd1);
        chk("single_rxcnt", rx_cnt, 64'd1);
        err_req = 1'b0;
        tick();
        chk("single_ackfall", {63'd0, err_ack}, 64'd0);
        pop1();
        chk("single_empty", {63'd0, empty}, 64'd1);
        chk("single_rd0",   rd_data, 64'd0);

        // back-to-back until full
        for (int i = 0; i < 16; i++) send(32'h100 + i);
        chk("b2b_level16", level, 64'd16);
        chk("b2b_full",    {63'd0, full}, 64'd1);
        chk("b2b_stall0",  {63'd0, stall}, 64'd0);
        err_data = 32'h110;
        err_req  = 1'b1;
        exp_q.push_back(32'h110);
        tick();
        chk("b2b_blk_ack",   {63'd0, err_ack}, 64'd0);
        chk("b2b_blk_stall", {63'd0, stall}, 64'd1);
        chk("b2b_blk_level", level, 64'd16);
        pop1();
        chk("b2b_pop_ack",   {63'd0, err_ack}, 64'd0);
        chk("b2b_pop_level", level, 64'd15);
        tick();
        chk("b2b_acc_ack",   {63'd0, err_ack}, 64'd1);
        chk("b2b_acc_level", level, 64'd16);
        chk("b2b_acc_stall", {63'd0, stall}, 64'd0);
        err_req = 1'b0;
        wait_ack(1'b0, "b2b_ackfall");
        drain();
        for (int i = 17; i < 20; i++) send(32'h100 + i);
        drain();

        // held request writes once
        cnt0 = rx_cnt;
        err_data = 32'hA5A5_0001;
        err_req  = 1'b1;
        exp_q.push_back(32'hA5A5_0001);
        repeat (10) tick();
        chk("held_rxcnt", rx_cnt, 64'(cnt0) + 64'd1);
        chk("held_level", level, 64'd1);
        chk("held_ack",   {63'd0, err_ack}, 64'd1);
        err_req = 1'b0;
        wait_ack(1'b0, "held_ackfall");
        drain();

        // wrap-around with interleaved reads
        for (int i = 0; i < 40; i++) begin
            send(32'h2000 + i);
            if (i % 3 == 2) begin
                pop1();
                pop1();
            end
            chk("wrap_level", level, exp_q.size());
        end
        drain();

        // simultaneous accept and pop at level 5
        for (int i = 0; i < 5; i++) send(32'h3000 + i);
        err_data = 32'h3005;
        err_req  = 1'b1;
        rd_en    = 1'b1;
        exp_q.push_back(32'h3005);
        tick();
        rd_en = 1'b0;
        chk("simul_level", level, 64'd5);
        chk("simul_ack",   {63'd0, err_ack}, 64'd1);
        chk("simul_head",  rd_data, 64'h3001);
        err_req = 1'b0;
        wait_ack(1'b0, "simul_ackfall");
        drain();

        // reset in S_ACK with level 3; still-high req is accepted again
        send(32'h4000);
        send(32'h4001);
        err_data = 32'h4002;
        err_req  = 1'b1;
        tick();
        chk("rmid_ack",   {63'd0, err_ack}, 64'd1);
        chk("rmid_level", level, 64'd3);
        rst = 1'b1;
        tick();
        chk("rmid_rst_ack",   {63'd0, err_ack}, 64'd0);
        chk("rmid_rst_level", level, 64'd0);
        chk("rmid_rst_rxcnt", rx_cnt, 64'd0);
        chk("rmid_rst_empty", {63'd0, empty}, 64'd1);
        exp_q.delete();
        exp_q.push_back(32'h4002);
        rst = 1'b0;
        tick();
        chk("rmid_re_ack",   {63'd0, err_ack}, 64'd1);
        chk("rmid_re_level", level, 64'd1);
        chk("rmid_re_rxcnt", rx_cnt, 64'd1);
        err_req = 1'b0;
        wait_ack(1'b0, "rmid_ackfall");
        drain();

        // saturation on a 2-bit counter instance: 1,2,3,3,3
        for (int i = 0; i < 5; i++) begin
            s_data = 32'h5000 + i;
            s_req  = 1'b1;
            tick();
            chk("sat_ack", {63'd0, s_ack}, 64'd1);
            s_req = 1'b0;
            tick();
            chk("sat_cnt", s_cnt, (i < 3) ? 64'(i + 1) : 64'd3);
        end
        chk("sat_level", s_level, 64'd5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
